// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction-fetch stage with PC, fetch queue and redirect flush
//
// Owns the PC, addresses the instruction ROM every cycle, buffers {pc, instr}
// pairs in a QDEPTH-entry queue and presents the queue head to decode.
// Decode outputs come only from registered queue state, so nothing on
// imem_rd or stall_d reaches them combinationally.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets (sticky misalign flag, fetch halts until reset). Without it the low
// two target bits are cleared and misalign is tied low.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   imem_addr         byte address to instruction ROM (= pc)
//   imem_rd           ROM data, combinational from imem_addr
//   stall_d           decode cannot accept this cycle
//   redirect          EX taken branch/jump, flush and refetch
//   redirect_pc       redirect target byte address
//   valid_d           instr_d/pc_d hold a real instruction
//   instr_d, pc_d     queue head (NOP / 0 when empty)
//   pc4_d             pc_d + 4
//   misalign          sticky misaligned-redirect flag

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic        misalign
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d_nxt;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] q_pc_q    [QDEPTH];
    logic [31:0] q_instr_q [QDEPTH];

    logic        push, pop, halted;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halted_q, halted_d;
    logic misalign_q, misalign_d;

    assign target = redirect_pc;

    always_comb begin
        halted_d   = halted_q;
        misalign_d = misalign_q;
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            halted_d   = 1'b1;
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    assign halted   = halted_q;
    assign misalign = misalign_q;
`else
    // Low target bits are discarded: fetch always stays word aligned.
    logic unused_target_lsbs;
    assign unused_target_lsbs = &{1'b0, redirect_pc[1:0]};
    assign target   = {redirect_pc[31:2], 2'b00};
    assign halted   = 1'b0;
    assign misalign = 1'b0;
`endif

    assign imem_addr = pc_q;

    assign valid_d = (count_q != '0);
    assign instr_d = valid_d ? q_instr_q[rd_ptr_q] : NOP;
    assign pc_d    = valid_d ? q_pc_q[rd_ptr_q] : 32'h0;
    assign pc4_d   = pc_d + 32'd4;

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign pop  = valid_d & ~stall_d;
    assign push = ~redirect & ~halted & ((count_q < QDEPTH_C) | pop);

    always_comb begin
        pc_d_nxt = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            // Flush wins over stall/push/pop; the popped head is killed by decode.
            pc_d_nxt = target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d_nxt = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d_nxt;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            q_pc_q[wr_ptr_q]    <= pc_q;
            q_instr_q[wr_ptr_q] <= imem_rd;
        end
    end

endmodule
